eth_tx: RTL

Ethernet transmitter: drains 34-bit packet words from a first-word-fall-through (FWFT) FIFO and drives them onto an egress port as framed data with start/end markers. It sits at the output side of the switch, opposite the receive path, and consumes the same word format the receive path writes: bit 33 = end, bit 32 = start, bits 31:0 = data. It enforces link backpressure, rejects malformed framing and inserts a programmable inter-packet gap.

---
 rtl/eth_pkg.sv | 16 +
 rtl/eth_tx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the switch packet path: FIFO word layout and
// transmitter state encoding.
package eth_pkg;

  localparam int WORD_W    = 34;
  localparam int START_BIT = 32;
  localparam int END_BIT   = 33;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/eth_tx.sv
// Egress transmitter: pops framed words from an FWFT FIFO, drives them onto
// the link with backpressure, drops malformed framing and spaces packets.
module eth_tx
  import eth_pkg::*;
#(
  parameter int IPG   = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] rd_data,
  input  logic              empty,
  output logic              rd_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_start,
  output logic              o_end,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_err,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int GAP_W = (IPG > 1) ? $clog2(IPG + 1) : 1;

  tx_state_t        state_r;
  logic [GAP_W-1:0] gap_cnt_r;

  logic free_s;
  logic hd_start_s;
  logic hd_end_s;
  logic pop_s;
  logic load_s;
  logic err_s;
  logic drop_s;
  logic gap_done_s;

  // Pop/load/error decisions for the FIFO head word in the current state.
  always_comb begin
    free_s     = !o_valid || i_ready;
    hd_start_s = rd_data[START_BIT];
    hd_end_s   = rd_data[END_BIT];
    pop_s      = 1'b0;
    load_s     = 1'b0;
    err_s      = 1'b0;
    drop_s     = 1'b0;
    // rstn gates the pop so the FIFO is left untouched while reset is held
    if (rstn && !empty) begin
      case (state_r)
        IDLE: begin
          if (hd_start_s) begin
            pop_s  = free_s;
            load_s = free_s;
          end else begin
            pop_s  = 1'b1;
            err_s  = 1'b1;
            drop_s = 1'b1;
          end
        end
        SEND: begin
          if (!hd_start_s) begin
            pop_s  = free_s;
            load_s = free_s;
          end else begin
            err_s  = 1'b1;
          end
        end
        GAP: begin
          pop_s = 1'b0;
        end
        default: begin
          pop_s = 1'b0;
        end
      endcase
    end else begin
      pop_s = 1'b0;
    end
    rd_en = pop_s;
  end

  // Leave the gap so that the state is IDLE in the first cycle where the
  // output is empty and the counter has reached zero.
  always_comb begin
    if (free_s) begin
      gap_done_s = (gap_cnt_r == GAP_W'(0)) ||
                   ((gap_cnt_r == GAP_W'(1)) && !o_valid);
    end else begin
      gap_done_s = 1'b0;
    end
  end

  // Framing FSM, output register, gap counter and drop counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      gap_cnt_r <= GAP_W'(0);
      o_data    <= {DATA_W{1'b0}};
      o_start   <= 1'b0;
      o_end     <= 1'b0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      drop_cnt  <= {CNT_W{1'b0}};
    end else begin
      o_err <= err_s;

      if (load_s) begin
        o_data  <= rd_data[DATA_W-1:0];
        o_start <= hd_start_s;
        o_end   <= hd_end_s;
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end

      if (drop_s && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end

      case (state_r)
        IDLE: begin
          if (load_s && hd_end_s) begin
            state_r   <= GAP;
            gap_cnt_r <= GAP_W'(IPG);
          end else if (load_s) begin
            state_r <= SEND;
          end
        end
        SEND: begin
          if ((load_s && hd_end_s) || err_s) begin
            state_r   <= GAP;
            gap_cnt_r <= GAP_W'(IPG);
          end
        end
        GAP: begin
          if (!o_valid && (gap_cnt_r != GAP_W'(0))) begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
          end
          if (gap_done_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
